// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if: control, score-write and status signals of the melody sequencer.
// master = board controller side, slave = sequencer side.
interface melody_sequencer_if #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned NUM_SONGS = 4,
  parameter int unsigned HP_W      = 16,
  parameter int unsigned DUR_W     = 4
);
  localparam int unsigned SEG = DEPTH / NUM_SONGS;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SW  = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
  localparam int unsigned IW  = (SEG > 1) ? $clog2(SEG) : 1;
  localparam int unsigned DW  = DUR_W + HP_W;

  logic          start;
  logic          stop;
  logic          pause;
  logic          loop_en;
  logic [SW-1:0] song_sel;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          piezo;
  logic          busy;
  logic [IW-1:0] note_idx;
  logic          done;

  modport master (
    output start, stop, pause, loop_en, song_sel, wr_en, wr_addr, wr_data,
    input  piezo, busy, note_idx, done
  );

  modport slave (
    input  start, stop, pause, loop_en, song_sel, wr_en, wr_addr, wr_data,
    output piezo, busy, note_idx, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a segment of a writeable score RAM on a piezo as a square wave.
// Define ARTIC_EN to silence the last GAP_CYC cycles of every non-rest note (detached notes).
module melody_sequencer #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned NUM_SONGS = 4,
  parameter int unsigned HP_W      = 16,
  parameter int unsigned DUR_W     = 4,
  parameter int unsigned TICK_DIV  = 250000,
  parameter int unsigned GAP_CYC   = 1000
) (
  input  logic               clk,
  input  logic               rst,
  melody_sequencer_if.slave  bus
);
  localparam int unsigned SEG = DEPTH / NUM_SONGS;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SW  = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
  localparam int unsigned IW  = (SEG > 1) ? $clog2(SEG) : 1;
  localparam int unsigned DW  = DUR_W + HP_W;
  localparam int unsigned TW  = $clog2(TICK_DIV);

  if (GAP_CYC >= TICK_DIV) begin : g_gap_check
    $error("GAP_CYC must be smaller than TICK_DIV");
  end

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, PAUSE} state_t;

  state_t           state;
  logic [DW-1:0]    ram [DEPTH];
  logic [DW-1:0]    rd_data;
  logic [AW-1:0]    rd_addr;
  logic             start_q;
  logic             fetch_ph;
  logic [SW-1:0]    song_q;
  logic [HP_W-1:0]  hp_q;
  logic [HP_W-1:0]  hp_cnt;
  logic [HP_W-1:0]  hp_cnt_n;
  logic [DUR_W-1:0] dur_cnt;
  logic [TW-1:0]    tick_cnt;
  logic             lvl;
  logic             lvl_n;
  logic             piezo_q;
  logic             busy_q;
  logic [IW-1:0]    idx_q;
  logic             done_q;
  logic             start_rise;
  logic             tick_wrap;
  logic             note_end;
  logic             seg_end;
  logic             gap_now;
  logic             gap_next;
  logic [DUR_W-1:0] rd_dur;
  logic [HP_W-1:0]  rd_hp;

  assign rd_addr    = AW'({song_q, idx_q});
  assign rd_dur     = rd_data[DW-1 -: DUR_W];
  assign rd_hp      = rd_data[HP_W-1:0];
  assign start_rise = bus.start & ~start_q;
  assign tick_wrap  = (tick_cnt == TW'(TICK_DIV - 1));
  assign note_end   = tick_wrap && (dur_cnt == DUR_W'(1));
  assign seg_end    = (idx_q == IW'(SEG - 1));

  assign bus.piezo    = piezo_q;
  assign bus.busy     = busy_q;
  assign bus.note_idx = idx_q;
  assign bus.done     = done_q;

  // Score RAM: one write port, registered read; not cleared by reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;
    rd_data <= ram[rd_addr];
  end

`ifdef ARTIC_EN
  localparam int unsigned GAP_START = TICK_DIV - GAP_CYC;
  // gap_now: current cycle is in the silent tail; gap_next: the following cycle will be.
  assign gap_now  = (GAP_CYC != 0) && (hp_q != '0) && (dur_cnt == DUR_W'(1)) &&
                    (tick_cnt >= TW'(GAP_START));
  assign gap_next = (GAP_CYC != 0) && (hp_q != '0) && (dur_cnt == DUR_W'(1)) && !tick_wrap &&
                    ((tick_cnt + TW'(1)) >= TW'(GAP_START));
`else
  assign gap_now  = 1'b0;
  assign gap_next = 1'b0;
`endif

  // Half-period counter: toggles the tone level on wrap; rests and gap cycles hold it.
  always_comb begin
    hp_cnt_n = hp_cnt;
    lvl_n    = lvl;
    if ((hp_q != '0) && !gap_now) begin
      if (hp_cnt == hp_q - HP_W'(1)) begin
        hp_cnt_n = '0;
        lvl_n    = ~lvl;
      end else begin
        hp_cnt_n = hp_cnt + HP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    start_q <= bus.start;
    if (rst) begin
      state    <= IDLE;
      fetch_ph <= 1'b0;
      song_q   <= '0;
      hp_q     <= '0;
      hp_cnt   <= '0;
      dur_cnt  <= '0;
      tick_cnt <= '0;
      lvl      <= 1'b0;
      piezo_q  <= 1'b0;
      busy_q   <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.stop) begin
        state    <= IDLE;
        fetch_ph <= 1'b0;
        hp_cnt   <= '0;
        dur_cnt  <= '0;
        tick_cnt <= '0;
        lvl      <= 1'b0;
        piezo_q  <= 1'b0;
        busy_q   <= 1'b0;
        idx_q    <= '0;
      end else begin
        case (state)
          IDLE: begin
            // done_q high means the song ended this cycle; a start edge now is dropped.
            if (start_rise && !done_q) begin
              state    <= FETCH;
              fetch_ph <= 1'b0;
              busy_q   <= 1'b1;
              song_q   <= bus.song_sel;
              idx_q    <= '0;
            end
          end
          FETCH: begin
            fetch_ph <= ~fetch_ph;
            if (fetch_ph) begin
              if (rd_dur != '0) begin
                state    <= PLAY;
                hp_q     <= rd_hp;
                dur_cnt  <= rd_dur;
                tick_cnt <= '0;
                hp_cnt   <= '0;
                lvl      <= 1'b0;
                piezo_q  <= 1'b0;
              end else if (bus.loop_en && (idx_q != '0)) begin
                idx_q <= '0;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                idx_q  <= '0;
              end
            end
          end
          PLAY: begin
            hp_cnt <= hp_cnt_n;
            lvl    <= lvl_n;
            if (tick_wrap) begin
              tick_cnt <= '0;
              dur_cnt  <= dur_cnt - DUR_W'(1);
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
            if (note_end) begin
              piezo_q  <= 1'b0;
              fetch_ph <= 1'b0;
              if (!seg_end) begin
                state <= FETCH;
                idx_q <= idx_q + IW'(1);
              end else if (bus.loop_en) begin
                state <= FETCH;
                idx_q <= '0;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                idx_q  <= '0;
              end
            end else if (bus.pause) begin
              state   <= PAUSE;
              piezo_q <= 1'b0;
            end else begin
              piezo_q <= lvl_n & ~gap_next;
            end
          end
          PAUSE: begin
            if (!bus.pause) begin
              state   <= PLAY;
              piezo_q <= lvl & ~gap_now;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
